// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the IF port, the MEM port, the backing
// memory and the per-stage stall lines of mem_port_arbiter.
// slave  : the arbiter's view (drives completions, memory request, stalls)
// master : the environment's view (requesters and backing memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  // data (LDUR/STUR) port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  // backing memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // hazard-unit stall lines
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between instruction fetch and the MEM stage. Each access runs
// IDLE -> GNT_D|GNT_I -> DONE -> IDLE; data wins simultaneous requests
// unless fetch has already waited MAX_WAIT data grants.
// Optional build macro ARB_PERF_CNT_EN adds grant / wait-cycle counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic                CLK,
  input  logic                resetl,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  state_t            state;
  state_t            state_n;
  logic              grant_d;
  logic              grant_i;
  logic [7:0]        starve_cnt;
  logic              fetch_hi;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              unused_addr_bits;

  // byte-lane bits below the word select never affect a fetch
  assign unused_addr_bits = ^bus.if_addr[1:0];

  // state register
  always_ff @(posedge CLK) begin
    if (resetl) state <= IDLE;
    else        state <= state_n;
  end

  // next-state and grant decode; requests are only sampled in IDLE
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (starve_cnt == MAX_W8))) begin
          state_n = GNT_D;
          grant_d = 1'b1;
        end else if (bus.if_req) begin
          state_n = GNT_I;
          grant_i = 1'b1;
        end
      end
      GNT_D, GNT_I: begin
        if (bus.mem_ack) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // request registers latched at grant, completion pulse and read data on ack,
  // and the fetch starvation counter
  always_ff @(posedge CLK) begin
    if (resetl) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fetch_hi    <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      starve_cnt  <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;

      if (grant_d) begin
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= {bus.if_addr[ADDR_W-1:3], 3'b000};
        mem_wdata_q <= '0;
        fetch_hi    <= bus.if_addr[2];
      end

      if (state == GNT_I && bus.mem_ack) begin
        if_ready_q <= 1'b1;
        if_rdata_q <= fetch_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end
      if (state == GNT_D && bus.mem_ack) begin
        d_ready_q <= 1'b1;
        d_rdata_q <= bus.mem_rdata;
      end

      // a data grant with fetch waiting is only possible below MAX_WAIT,
      // so the increment saturates without an explicit limit check
      if (grant_d && bus.if_req)
        starve_cnt <= starve_cnt + 8'd1;
      else if (state == IDLE)
        starve_cnt <= '0;
    end
  end

  assign bus.mem_req   = (state == GNT_D) || (state == GNT_I);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.d_req & ~d_ready_q;

`ifdef ARB_PERF_CNT_EN
  // grant and wait-cycle counters, free-running with natural 32-bit wrap
  always_ff @(posedge CLK) begin
    if (resetl) begin
      perf_if_grants   <= '0;
      perf_d_grants    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (grant_i) perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_d) perf_d_grants  <= perf_d_grants + 32'd1;
      if (bus.stall_if || bus.stall_mem)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
